// File: rtl/seq_run_launcher.sv
// Purpose : drives a valid/ready child through a programmed number of runs and
//           pulses child_reset for one cycle (CLEAR) before every run.
// Latency : each run costs CLEAR + LAUNCH + k WAIT cycles (k = cycles from
//           valid rise to ready), so done pulses N*(k+2)+1 cycles after start.
// Backpr. : child_valid is held as a level until child_ready is seen in WAIT;
//           start is ignored while busy or in DONE; an optional per-run
//           timeout abandons a child that never answers.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (also resets the child)
//   start        one-cycle batch request, sampled only in IDLE
//   iterations   number of runs, sampled together with start
//   child_ready  ready from the launched component
//   child_valid  valid to the launched component (decode of LAUNCH/WAIT)
//   child_reset  reset to the launched component (CLEAR, reset, post-reset)
//   busy         registered, high from the cycle after start until DONE
//   done         one-cycle completion pulse (decode of DONE)
//   timed_out    sticky: a run hit the timeout; cleared by start or reset
//   iter_count   runs completed in the current/last batch
//   cycle_count  saturating count of CLEAR/LAUNCH/WAIT cycles in the batch
module seq_run_launcher #(
  parameter int ITER_W  = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iterations,
  input  logic              child_ready,
  output logic              child_valid,
  output logic              child_reset,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [ITER_W-1:0] iter_count,
  output logic [CNT_W-1:0]  cycle_count
);

  // The wait counter only has to reach TIMEOUT-1: the cycle it holds that
  // value is the TIMEOUT-th WAIT cycle, which either succeeds or times out.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ITER_W-1:0] target;
  logic [WAIT_W-1:0] wait_cnt;
  logic              post_reset;

  logic              accept;
  logic              ready_hit;
  logic              timeout_hit;
  logic              last_run;
  logic              active;
  logic              active_nxt;

  // ---------------------------------------------------------------------------
  // Event decodes
  // ---------------------------------------------------------------------------
  assign accept    = (state == S_IDLE) && start;
  assign ready_hit = (state == S_WAIT) && child_ready;
  // Ready in the timeout cycle wins, hence the !child_ready term.
  assign timeout_hit = (TIMEOUT != 0) && (state == S_WAIT) && !child_ready &&
                       (wait_cnt == WAIT_LAST);
  assign last_run  = (iter_count + ITER_W'(1)) == target;
  assign active    = (state == S_CLEAR) || (state == S_LAUNCH) || (state == S_WAIT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (iterations != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR:  state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ready_hit) begin
          state_nxt = last_run ? S_DONE : S_CLEAR;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign active_nxt = (state_nxt == S_CLEAR) || (state_nxt == S_LAUNCH) ||
                      (state_nxt == S_WAIT);

  // ---------------------------------------------------------------------------
  // State decodes to the child. Gating with reset makes the reset cycle itself
  // quiet even though the state register only clears at the following edge.
  // post_reset stretches child_reset one cycle past the launcher's reset.
  // ---------------------------------------------------------------------------
  assign child_valid = !reset && ((state == S_LAUNCH) || (state == S_WAIT));
  assign child_reset = reset || post_reset || (state == S_CLEAR);
  assign done        = !reset && (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      post_reset  <= 1'b1;
      busy        <= 1'b0;
      timed_out   <= 1'b0;
      iter_count  <= '0;
      cycle_count <= '0;
      target      <= '0;
      wait_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      post_reset <= 1'b0;
      busy       <= active_nxt;

      if (accept) begin
        target      <= iterations;
        iter_count  <= '0;
        cycle_count <= '0;
        timed_out   <= 1'b0;
      end

      if (active && (cycle_count != CNT_MAX)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end

      // Counter restarts for every run; LAUNCH always precedes the first WAIT.
      if (state == S_LAUNCH) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (ready_hit) begin
        iter_count <= iter_count + ITER_W'(1);
      end

      if (timeout_hit) begin
        timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_run_launcher.sv
// Purpose : randomized bench for seq_run_launcher; every batch is expanded into
//           a per-cycle schedule of stimulus and expected outputs.
// Latency : the schedule is built from run lengths (2 + k per run, +1 DONE).
// Backpr. : child_ready is driven by the schedule; stray starts while busy.
module tb_seq_run_launcher;

  localparam int ITER_W  = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ITER_W-1:0] iterations;
  logic              child_ready;
  logic              child_valid;
  logic              child_reset;
  logic              busy;
  logic              done;
  logic              timed_out;
  logic [ITER_W-1:0] iter_count;
  logic [CNT_W-1:0]  cycle_count;

  always #5 clk = ~clk;

  seq_run_launcher #(
    .ITER_W (ITER_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .iterations (iterations),
    .child_ready(child_ready),
    .child_valid(child_valid),
    .child_reset(child_reset),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .iter_count (iter_count),
    .cycle_count(cycle_count)
  );

  // One scheduled cycle: inputs to drive, outputs expected.
  typedef struct {
    bit e_rst;
    bit e_st;
    int e_it;
    bit e_rdy;
    bit e_v;
    bit e_cr;
    bit e_b;
    bit e_d;
    bit e_to;
    int e_iter;
    int e_cyc;
    bit e_regs;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  bit   cur_vld = 1'b0;
  int   kq[$];
  int   checks = 0;
  int   errors = 0;
  int   done_off;

  // Values the registered outputs are showing right now.
  int m_iter = 0;
  int m_cyc  = 0;
  bit m_to   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit nz(input bit all1);
    return all1 ? 1'b1 : ($urandom_range(0, 1) == 1);
  endfunction

  function automatic bit js();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic int jit();
    return int'($urandom_range(1, 255));
  endfunction

  function automatic void add(input bit rst, input bit st, input int it, input bit rdy,
                              input bit v, input bit cr, input bit b, input bit d,
                              input bit regs);
    cyc_t e;
    e.e_rst  = rst;
    e.e_st   = st;
    e.e_it   = it;
    e.e_rdy  = rdy;
    e.e_v    = v;
    e.e_cr   = cr;
    e.e_b    = b;
    e.e_d    = d;
    e.e_to   = m_to;
    e.e_iter = m_iter;
    e.e_cyc  = m_cyc;
    e.e_regs = regs;
    plan.push_back(e);
  endfunction

  function automatic void inc_cyc();
    m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
  endfunction

  // A batch of n runs; kq[r] is how many cycles after valid rises the child
  // answers in run r (beyond TIMEOUT means it never answers in time).
  function automatic void build_batch(input int n, input bit all1);
    int gap;
    add(1'b0, 1'b1, n, nz(all1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_iter = 0;
    m_cyc  = 0;
    m_to   = 1'b0;
    for (int r = 0; r < n; r++) begin
      int kk;
      int wmax;
      kk   = kq[r];
      wmax = (kk <= TIMEOUT) ? kk : TIMEOUT;
      add(1'b0, js(), jit(), nz(all1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      inc_cyc();
      add(1'b0, js(), jit(), nz(all1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      inc_cyc();
      for (int w = 1; w <= wmax; w++) begin
        add(1'b0, js(), jit(), (w == kk), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        inc_cyc();
      end
      if (kk <= TIMEOUT) begin
        m_iter++;
      end else begin
        m_to = 1'b1;
        break;
      end
    end
    add(1'b0, js(), jit(), nz(all1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    gap = int'($urandom_range(1, 2));
    for (int g = 0; g < gap; g++) begin
      add(1'b0, 1'b0, jit(), nz(all1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endfunction

  // n reset cycles plus the one post-reset cycle the child stays in reset.
  // In the first reset cycle the registers still show pre-reset values unless
  // reset was already sampled before the schedule starts.
  function automatic void add_reset(input int n, input bit first_known);
    m_iter = 0;
    m_cyc  = 0;
    m_to   = 1'b0;
    for (int i = 0; i < n; i++) begin
      add(1'b1, 1'b0, jit(), nz(1'b0), 1'b0, 1'b1, 1'b0, 1'b0, first_known || (i > 0));
    end
    add(1'b0, 1'b0, jit(), nz(1'b0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic void set_k(input int n, input int k);
    kq.delete();
    for (int r = 0; r < n; r++) kq.push_back(k);
  endfunction

  task automatic play();
    int j;
    cyc_t e;
    j        = 0;
    done_off = -1;
    while (plan.size() > 0) begin
      @(posedge clk);
      #1;
      e           = plan.pop_front();
      reset       = e.e_rst;
      start       = e.e_st;
      iterations  = ITER_W'(e.e_it);
      child_ready = e.e_rdy;
      cur         = e;
      cur_vld     = 1'b1;
      @(negedge clk);
      if (done === 1'b1 && done_off < 0) done_off = j;
      j++;
    end
  endtask

  // Per-cycle comparison against the schedule.
  always @(negedge clk) begin
    if (cur_vld) begin
      chk("child_valid", {31'd0, child_valid}, {31'd0, cur.e_v});
      chk("child_reset", {31'd0, child_reset}, {31'd0, cur.e_cr});
      chk("done", {31'd0, done}, {31'd0, cur.e_d});
      if (cur.e_regs) begin
        chk("busy", {31'd0, busy}, {31'd0, cur.e_b});
        chk("timed_out", {31'd0, timed_out}, {31'd0, cur.e_to});
        chk("iter_count", 32'(iter_count), cur.e_iter);
        chk("cycle_count", 32'(cycle_count), cur.e_cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    iterations  = '0;
    child_ready = 1'b0;

    // Power-on reset.
    add_reset(3, 1'b1);
    play();

    // Three runs, child answers 2 cycles after valid rises.
    set_k(3, 2);
    build_batch(3, 1'b0);
    play();
    chk("lit_done_off_3x2", done_off, 13);
    chk("lit_iter_3x2", 32'(iter_count), 3);
    chk("lit_cyc_3x2", 32'(cycle_count), 12);
    chk("lit_to_3x2", {31'd0, timed_out}, 0);

    // Zero iterations.
    build_batch(0, 1'b0);
    play();
    chk("lit_done_off_zero", done_off, 1);
    chk("lit_cyc_zero", 32'(cycle_count), 0);

    // Child never answers.
    set_k(2, 100);
    build_batch(2, 1'b0);
    play();
    chk("lit_done_off_timeout", done_off, 11);
    chk("lit_to_timeout", {31'd0, timed_out}, 1);
    chk("lit_iter_timeout", 32'(iter_count), 0);
    chk("lit_cyc_timeout", 32'(cycle_count), 10);

    // Next start clears timed_out.
    set_k(1, 3);
    build_batch(1, 1'b0);
    play();
    chk("lit_to_cleared", {31'd0, timed_out}, 0);
    chk("lit_iter_after_to", 32'(iter_count), 1);

    // Reset during WAIT of run 2 of 4.
    set_k(4, 2);
    build_batch(4, 1'b0);
    while (plan.size() > 7) void'(plan.pop_back());
    add_reset(1, 1'b0);
    play();
    chk("lit_done_off_abort", done_off, -1);
    chk("lit_busy_abort", {31'd0, busy}, 0);
    chk("lit_cyc_abort", 32'(cycle_count), 0);

    // Ready held high throughout: 3 cycles per run.
    set_k(3, 1);
    build_batch(3, 1'b1);
    play();
    chk("lit_done_off_const_rdy", done_off, 10);
    chk("lit_cyc_const_rdy", 32'(cycle_count), 9);

    // Ready on the timeout cycle succeeds; 20 busy cycles saturate at 15.
    set_k(2, TIMEOUT);
    build_batch(2, 1'b0);
    play();
    chk("lit_done_off_edge", done_off, 21);
    chk("lit_to_edge", {31'd0, timed_out}, 0);
    chk("lit_iter_edge", 32'(iter_count), 2);
    chk("lit_cyc_sat", 32'(cycle_count), 15);

    // Randomized batches with occasional resets at arbitrary points.
    for (int b = 0; b < 40; b++) begin
      int n;
      n = int'($urandom_range(0, 5));
      kq.delete();
      for (int r = 0; r < n; r++) kq.push_back(int'($urandom_range(1, TIMEOUT + 3)));
      build_batch(n, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 7) == 0) begin
        int a;
        a = int'($urandom_range(1, plan.size() - 1));
        while (plan.size() > a) void'(plan.pop_back());
        add_reset(int'($urandom_range(1, 2)), 1'b0);
      end
      play();
    end

    @(posedge clk);
    cur_vld = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_run_launcher.md
Name: seq_run_launcher

Overview:
- Upstream driver for a generated top-level component with a valid/ready handshake.
- Launches the component a programmable number of times and returns it to idle between runs with a one-cycle child reset pulse.
- Measures total busy cycles and flags a child that never raises ready.
- Sits between the host/testbench control interface and the top-level valid/ready/reset pins.

Parameters:
ITER_W, 8, width of iteration count request and counter
CNT_W, 32, width of total cycle counter (saturating)
TIMEOUT, 1024, max cycles per run waiting for child ready; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a batch; sampled only in IDLE
iterations  input  ITER_W  number of runs requested; sampled with start
child_ready  input  1  ready from launched component
child_valid  output  1  valid to launched component
child_reset  output  1  reset to launched component
busy  output  1  high from cycle after accepted start until DONE entered
done  output  1  single-cycle pulse at batch completion
timed_out  output  1  sticky error flag; cleared by next accepted start or reset
iter_count  output  ITER_W  runs completed in current/last batch
cycle_count  output  CNT_W  cycles spent in LAUNCH/WAIT/CLEAR in current/last batch

Behaviour:
- One clock; reset is synchronous and active-high.
- All state updates on posedge clk.
- Reset (any state, including mid-run) forces:
  - state=IDLE
  - child_valid=0, busy=0, done=0, timed_out=0, iter_count=0, cycle_count=0
  - child_reset=1 in the reset cycle and the following cycle, so the child is cleared together with the launcher.
- States: IDLE, CLEAR, LAUNCH, WAIT, DONE.
- IDLE:
  - start=1 and iterations!=0: latch iterations into target, clear iter_count/cycle_count/timed_out, go to CLEAR.
  - start=1 and iterations=0: go directly to DONE. No child activity; counters and timed_out cleared.
- CLEAR:
  - Drive child_reset=1 for exactly one cycle, then go to LAUNCH.
  - Guarantees the child starts each run from its idle state.
- LAUNCH:
  - Drive child_valid=1, go to WAIT.
  - child_valid stays 1 through WAIT (level, not pulse).
- WAIT:
  - child_valid=1.
  - child_ready=1 → deassert child_valid next cycle, increment iter_count (wraps only if target=2^ITER_W−1+1 impossible; target ≤ max).
    - If iter_count+1==target → DONE.
    - Else → CLEAR (next run).
  - Per-run wait counter increments each WAIT cycle; reset on entering LAUNCH.
  - TIMEOUT!=0 and wait counter reaches TIMEOUT with child_ready=0 → set timed_out=1, go to DONE without incrementing iter_count.
  - child_ready and timeout in the same cycle → ready wins (run counts, no timeout).
- DONE:
  - done=1 for one cycle, busy=0, child_valid=0, then IDLE.
  - start asserted during DONE is ignored.
- child_ready=1 observed in IDLE/CLEAR/LAUNCH is ignored (no count).
- start while busy is ignored; iterations input is not re-sampled.
- cycle_count:
  - Increments every cycle in CLEAR, LAUNCH or WAIT.
  - Saturates at 2^CNT_W−1, never wraps.
  - Holds value after DONE until next accepted start or reset.
- Latency, for a child answering ready k cycles after valid rises:
  - Each run costs 1 (CLEAR) + 1 (LAUNCH) + k cycles.
  - N runs → done pulses N·(k+2)+1 cycles after the start cycle.
- Outputs are registered except child_valid/child_reset/done, which are state decodes.
- All outputs must be defined in every state (no latches, no X).

Test Plan:
- Reset held 3 cycles, released → all outputs 0 except child_reset=1 through first post-reset cycle; state IDLE.
- start, iterations=3, child_ready returned 2 cycles after child_valid rises:
  - 3 child_reset pulses, 3 valid windows.
  - done at cycle 13 after start.
  - iter_count=3, cycle_count=12, timed_out=0.
- start, iterations=0 → done pulse next cycle, no child_valid/child_reset activity, counters 0.
- TIMEOUT=8, child_ready never asserted, iterations=2:
  - child_valid high 8 WAIT cycles.
  - timed_out=1, iter_count=0, done pulses.
  - next start clears timed_out.
- Mid-run reset (WAIT state of run 2 of 4):
  - child_valid drops, child_reset=1 for 2 cycles.
  - counters 0, busy=0, no done pulse.
- Edge/robustness:
  - start pulsed while busy → no effect.
  - child_ready=1 constantly → each run takes 3 cycles.
  - ready coinciding with timeout cycle counts as success.
  - CNT_W=4 saturates at 15.
